// File: rtl/axi_read_burst_sequencer.sv
// rtl/axi_read_burst_sequencer.sv - turns one AXI AR request into per-beat memory read requests.
// Optional WRAP addressing is enabled by defining BURST_WRAP_EN.
module axi_read_burst_sequencer #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_00FF,
  parameter logic [2:0]  MAX_SIZE   = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        beat_valid,
  input  logic        beat_ready,
  output logic [31:0] beat_addr,
  output logic [2:0]  beat_size,
  output logic        beat_last,
  output logic        beat_err,
  output logic        busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state;
  logic [7:0]  remaining;
  logic [1:0]  burst;
  logic        mode_err;
  logic        size_bad_in;
  logic        mode_err_in;
  logic [31:0] step;
  logic [31:0] next_addr;
`ifdef BURST_WRAP_EN
  logic        wrap_act;
  logic        wrap_act_in;
  logic [31:0] wrap_lo;
  logic [31:0] wrap_hi;
  logic [31:0] span_in;
  logic [31:0] lo_in;
`endif

  // Burst-wide error causes are decided once at acceptance; only the range check varies per beat.
  always_comb begin
    size_bad_in = (arsize > MAX_SIZE);
`ifdef BURST_WRAP_EN
    span_in     = ({24'd0, arlen} + 32'd1) << arsize;
    lo_in       = araddr & ~(span_in - 32'd1);
    wrap_act_in = (arburst == 2'b10) && !size_bad_in &&
                  ((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15));
    mode_err_in = size_bad_in || (arburst == 2'b11) || ((arburst == 2'b10) && !wrap_act_in);
`else
    mode_err_in = size_bad_in || arburst[1];
`endif
  end

  always_comb begin
    step = (beat_size <= MAX_SIZE) ? (32'd1 << beat_size) : 32'd0;
    if (burst == 2'b00)
      next_addr = beat_addr;
    else
      next_addr = beat_addr + step;
`ifdef BURST_WRAP_EN
    if (wrap_act && (next_addr == wrap_hi))
      next_addr = wrap_lo;
`endif
  end

  assign beat_last = beat_valid && (remaining == 8'd0);
  assign beat_err  = beat_valid && (mode_err || (beat_addr > ADDR_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      arready    <= 1'b1;
      beat_valid <= 1'b0;
      busy       <= 1'b0;
      beat_addr  <= 32'd0;
      beat_size  <= 3'd0;
      remaining  <= 8'd0;
      burst      <= 2'b00;
      mode_err   <= 1'b0;
`ifdef BURST_WRAP_EN
      wrap_act   <= 1'b0;
      wrap_lo    <= 32'd0;
      wrap_hi    <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            state      <= ISSUE;
            arready    <= 1'b0;
            beat_valid <= 1'b1;
            busy       <= 1'b1;
            beat_addr  <= araddr;
            beat_size  <= arsize;
            remaining  <= arlen;
            burst      <= arburst;
            mode_err   <= mode_err_in;
`ifdef BURST_WRAP_EN
            wrap_act   <= wrap_act_in;
            wrap_lo    <= lo_in;
            wrap_hi    <= lo_in + span_in;
`endif
          end
        end
        ISSUE: begin
          if (beat_ready) begin
            if (remaining == 8'd0) begin
              state      <= IDLE;
              arready    <= 1'b1;
              beat_valid <= 1'b0;
              busy       <= 1'b0;
            end else begin
              beat_addr  <= next_addr;
              remaining  <= remaining - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_burst_sequencer.sv
// tb/tb_axi_read_burst_sequencer.sv - directed table plus randomized bursts against a reference model.
module tb_axi_read_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [2:0]  beat_size;
  logic        beat_last;
  logic        beat_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_a[$];
  logic        obs_e[$];
  logic        obs_l[$];
  logic [31:0] exp_a[$];
  logic        exp_e[$];

  typedef struct packed {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                mode;
    logic [3:0][31:0]  ea;
    logic [3:0]        ee;
  } vec_t;

  vec_t tbl[8];

  axi_read_burst_sequencer dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .beat_addr(beat_addr), .beat_size(beat_size),
    .beat_last(beat_last), .beat_err(beat_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] z,
                              input logic [1:0] b, input int m, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                              input logic [3:0] ee);
    mk.addr  = a;
    mk.len   = l;
    mk.size  = z;
    mk.burst = b;
    mk.mode  = m;
    mk.ea    = {e3, e2, e1, e0};
    mk.ee    = ee;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] s, input logic [7:0] l,
                                         input logic [2:0] z, input logic [1:0] b, input int i);
    longint st;
    longint sp;
    longint base;
    longint off;
    st = (z <= 3'd3) ? (longint'(1) << z) : 0;
    sp = 0;
    base = 0;
    off = 0;
    if (b == 2'b00) return s;
`ifdef BURST_WRAP_EN
    if (b == 2'b10 && (l == 1 || l == 3 || l == 7 || l == 15) && st != 0) begin
      sp   = (longint'(l) + 1) * st;
      base = longint'(s) - (longint'(s) % sp);
      off  = (longint'(s) - base + longint'(i) * st) % sp;
      return 32'(base + off);
    end
`endif
    return 32'(longint'(s) + longint'(i) * st);
  endfunction

  function automatic logic m_err(input logic [7:0] l, input logic [2:0] z, input logic [1:0] b,
                                 input logic [31:0] a);
    bit wrap_ok;
    wrap_ok = 1'b0;
`ifdef BURST_WRAP_EN
    wrap_ok = (l == 1 || l == 3 || l == 7 || l == 15);
`endif
    return (z > 3'd3) || (b == 2'b11) || (b == 2'b10 && !wrap_ok) || (a > 32'h0000_00FF);
  endfunction

  task automatic model_fill(input logic [31:0] s, input logic [7:0] l, input logic [2:0] z,
                            input logic [1:0] b);
    logic [31:0] a;
    exp_a.delete();
    exp_e.delete();
    for (int i = 0; i <= int'(l); i++) begin
      a = m_addr(s, l, z, b, i);
      exp_a.push_back(a);
      exp_e.push_back(m_err(l, z, b, a));
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake cycle.
  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] z,
                       input logic [1:0] b);
    chk("ar_ready_idle", 32'(arready), 32'd1);
    arvalid = 1'b1;
    araddr  = a;
    arlen   = l;
    arsize  = z;
    arburst = b;
    @(negedge clk);
    arvalid = 1'b0;
    araddr  = $urandom;
    arlen   = 8'($urandom);
    arsize  = 3'($urandom);
    arburst = 2'($urandom);
  endtask

  task automatic collect(input int mode, input logic [2:0] z, output int cyc);
    bit          done;
    logic        pv;
    logic        pr;
    logic [31:0] pa;
    logic        pe;
    logic        pl;
    obs_a.delete();
    obs_e.delete();
    obs_l.delete();
    done = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
    pa = 32'd0;
    pe = 1'b0;
    pl = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (mode == 0)      beat_ready = 1'b1;
      else if (mode == 2) beat_ready = (cyc >= 3);
      else                beat_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2) begin
        arvalid = !beat_ready;
        araddr  = 32'h0000_0055;
        arlen   = 8'd0;
      end
      chk("issue_valid", 32'(beat_valid), 32'd1);
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_arready", 32'(arready), 32'd0);
      chk("issue_size", 32'(beat_size), 32'(z));
      if (pv && !pr) begin
        chk("stall_addr", beat_addr, pa);
        chk("stall_err", 32'(beat_err), 32'(pe));
        chk("stall_last", 32'(beat_last), 32'(pl));
      end
      if (beat_valid && beat_ready) begin
        obs_a.push_back(beat_addr);
        obs_e.push_back(beat_err);
        obs_l.push_back(beat_last);
        if (beat_last) done = 1'b1;
      end
      pv = beat_valid;
      pr = beat_ready;
      pa = beat_addr;
      pe = beat_err;
      pl = beat_last;
      cyc++;
      @(negedge clk);
    end
    beat_ready = 1'b0;
    arvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no last beat after %0d cycles", cyc);
    end
    chk("bubble_arready", 32'(arready), 32'd1);
    chk("bubble_valid", 32'(beat_valid), 32'd0);
    chk("bubble_busy", 32'(busy), 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [7:0] l, input logic [2:0] z,
                     input logic [1:0] b, input int mode);
    int cyc;
    int n;
    do_ar(a, l, z, b);
    collect(mode, z, cyc);
    chk("beat_count", 32'(obs_a.size()), 32'(int'(l) + 1));
    if (mode == 0) chk("burst_cycles", 32'(cyc), 32'(int'(l) + 1));
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("addr[%0d]", i), obs_a[i], exp_a[i]);
      chk($sformatf("err[%0d]", i), 32'(obs_e[i]), 32'(exp_e[i]));
      chk($sformatf("last[%0d]", i), 32'(obs_l[i]), 32'(i == int'(l)));
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [7:0]  l;
    logic [2:0]  z;
    logic [1:0]  b;

    tbl[0] = mk(32'h10, 8'd3, 3'd2, 2'b01, 0, 32'h10, 32'h14, 32'h18, 32'h1C, 4'b0000);
    tbl[1] = mk(32'hF8, 8'd3, 3'd3, 2'b01, 0, 32'hF8, 32'h100, 32'h108, 32'h110, 4'b1110);
    tbl[2] = mk(32'h40, 8'd2, 3'd5, 2'b01, 1, 32'h40, 32'h40, 32'h40, 32'h0, 4'b0111);
    tbl[3] = mk(32'h40, 8'd2, 3'd0, 2'b00, 1, 32'h40, 32'h40, 32'h40, 32'h0, 4'b0000);
    tbl[4] = mk(32'h00, 8'd1, 3'd0, 2'b01, 2, 32'h0, 32'h1, 32'h0, 32'h0, 4'b0000);
`ifdef BURST_WRAP_EN
    tbl[5] = mk(32'h38, 8'd3, 3'd3, 2'b10, 0, 32'h38, 32'h20, 32'h28, 32'h30, 4'b0000);
`else
    tbl[5] = mk(32'h38, 8'd3, 3'd3, 2'b10, 0, 32'h38, 32'h40, 32'h48, 32'h50, 4'b1111);
`endif
    tbl[6] = mk(32'hFFFF_FFFF, 8'd1, 3'd0, 2'b01, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 4'b0001);
    tbl[7] = mk(32'h20, 8'd1, 3'd2, 2'b11, 1, 32'h20, 32'h24, 32'h0, 32'h0, 4'b0011);

    rst = 1'b1;
    arvalid = 1'b0;
    araddr = 32'd0;
    arlen = 8'd0;
    arsize = 3'd0;
    arburst = 2'b00;
    beat_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_valid", 32'(beat_valid), 32'd0);
    chk("rst_addr", beat_addr, 32'd0);
    chk("rst_size", 32'(beat_size), 32'd0);
    chk("rst_last", 32'(beat_last), 32'd0);
    chk("rst_err", 32'(beat_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      exp_a.delete();
      exp_e.delete();
      for (int i = 0; i <= int'(tbl[k].len); i++) begin
        exp_a.push_back(tbl[k].ea[i]);
        exp_e.push_back(tbl[k].ee[i]);
      end
      run(tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, tbl[k].mode);
    end

    // Abort an 8-beat burst right after its second beat is taken.
    do_ar(32'h80, 8'd7, 3'd2, 2'b01);
    beat_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(beat_valid), 32'd0);
    chk("abort_arready", 32'(arready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", beat_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat_ready = 1'b0;
    @(negedge clk);
    model_fill(32'h30, 8'd1, 3'd0, 2'b01);
    run(32'h30, 8'd1, 3'd0, 2'b01, 0);

    model_fill(32'h0, 8'd255, 3'd0, 2'b01);
    run(32'h0, 8'd255, 3'd0, 2'b01, 0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFC0 + $urandom_range(0, 63);
      else                           s = $urandom_range(0, 32'h130);
      if ($urandom_range(0, 1) == 0) l = 8'($urandom_range(0, 20));
      else                           l = 8'((1 << $urandom_range(1, 4)) - 1);
      z = 3'($urandom_range(0, 4));
      b = 2'($urandom_range(0, 3));
      if (z <= 3'd3) s = s & ~((32'd1 << z) - 32'd1);
      model_fill(s, l, z, b);
      run(s, l, z, b, ($urandom_range(0, 2) == 0) ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
